// File: rtl/pa_cal_mean_ctrl.sv
// pa_cal_mean_ctrl
// ----------------
// Sequencer for the mean-calculation path. It reads N words from the data
// RAM and streams them to the sum unit with start/valid/last framing. It
// then captures the returned sum and divides it by N with a restoring
// divider that produces one quotient bit per cycle, MSB first. The floor
// mean is presented together with a one-cycle done pulse.
//
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_start           start request, sampled only in IDLE
//   i_num_elem        element count N (1..2^SIZE_ADDR), latched on start
//   o_rd_en/o_rd_addr RAM read strobe and address
//   i_rd_data         RAM read data, valid one cycle after o_rd_en
//   o_sum_start       one-cycle accumulator clear for the sum unit
//   o_sum_valid       o_sum_data valid this cycle
//   o_sum_data        element to accumulate (combinational pass of i_rd_data)
//   o_sum_last        marks the final element
//   i_sum/i_sum_done  accumulated sum and its completion flag
//   o_mean            floor(sum/N), held until the next completion
//   o_busy            high in every state except IDLE
//   o_done            one-cycle completion pulse
//   o_err             high with o_done when N was invalid
module pa_cal_mean_ctrl #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_ADDR = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR:0]   i_num_elem,
  output logic                 o_rd_en,
  output logic [SIZE_ADDR-1:0] o_rd_addr,
  input  logic [SIZE_DATA-1:0] i_rd_data,
  output logic                 o_sum_start,
  output logic                 o_sum_valid,
  output logic [SIZE_DATA-1:0] o_sum_data,
  output logic                 o_sum_last,
  input  logic [SIZE_DATA-1:0] i_sum,
  input  logic                 i_sum_done,
  output logic [SIZE_DATA-1:0] o_mean,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int CNT_W = $clog2(SIZE_DATA);
  localparam logic [SIZE_ADDR:0]   N_MAX    = {1'b1, {SIZE_ADDR{1'b0}}};
  localparam logic [SIZE_ADDR:0]   ONE_N    = 1;
  localparam logic [SIZE_ADDR-1:0] ONE_A    = 1;
  localparam logic [CNT_W-1:0]     ONE_C    = 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SIZE_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READ,
    S_DRAIN,
    S_WAIT_SUM,
    S_DIV,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [SIZE_ADDR:0]   n_q;
  logic [SIZE_ADDR-1:0] addr_q;
  logic                 rd_en_q;
  logic                 sum_start_q;
  logic                 sum_valid_q;
  logic                 sum_last_q;
  logic [SIZE_DATA-1:0] dvd_q;       // dividend, becomes the quotient as bits shift in
  logic [SIZE_DATA-1:0] rem_q;       // remainder, always < N so SIZE_DATA bits suffice
  logic [CNT_W-1:0]     cnt_q;
  logic [SIZE_DATA-1:0] mean_q;
  logic                 done_q;
  logic                 err_q;
  logic                 busy_q;
  logic                 err_flag_q;

  logic                 n_ok;
  logic                 last_addr;
  logic [SIZE_DATA:0]   divisor;
  logic [SIZE_DATA:0]   rem_shift;
  logic                 q_bit;
  logic [SIZE_DATA-1:0] rem_d;
  logic [SIZE_DATA-1:0] quo_d;

  assign n_ok      = (i_num_elem != '0) && (i_num_elem <= N_MAX);
  assign last_addr = ({1'b0, addr_q} == (n_q - ONE_N));

  // Restoring division step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. The difference is
  // below the divisor, so the truncated subtraction is exact.
  always_comb begin
    divisor   = {{(SIZE_DATA - SIZE_ADDR){1'b0}}, n_q};
    rem_shift = {rem_q, dvd_q[SIZE_DATA-1]};
    q_bit     = (rem_shift >= divisor);
    rem_d     = rem_shift[SIZE_DATA-1:0];
    if (q_bit) begin
      rem_d = rem_shift[SIZE_DATA-1:0] - divisor[SIZE_DATA-1:0];
    end
    quo_d     = {dvd_q[SIZE_DATA-2:0], q_bit};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      sum_start_q <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_last_q  <= 1'b0;
      dvd_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      mean_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      // Framing stage: valid/last follow the read strobe by the RAM latency.
      sum_valid_q <= rd_en_q;
      sum_last_q  <= rd_en_q & last_addr;
      sum_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            n_q    <= i_num_elem;
            busy_q <= 1'b1;
            if (n_ok) begin
              err_flag_q  <= 1'b0;
              addr_q      <= '0;
              sum_start_q <= 1'b1;
              state_q     <= S_CLEAR;
            end else begin
              // Invalid N reports straight away with a zero mean.
              err_flag_q <= 1'b1;
              mean_q     <= '0;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end

        S_CLEAR: begin
          rd_en_q <= 1'b1;
          addr_q  <= '0;
          state_q <= S_READ;
        end

        S_READ: begin
          if (last_addr) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_q + ONE_A;
          end
        end

        // The last element is on the bus while the state sits in DRAIN.
        S_DRAIN: begin
          state_q <= S_WAIT_SUM;
        end

        S_WAIT_SUM: begin
          if (i_sum_done) begin
            dvd_q   <= i_sum;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_DIV;
          end
        end

        S_DIV: begin
          dvd_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + ONE_C;
          if (cnt_q == CNT_LAST) begin
            // Final quotient bit is folded in as the mean is loaded, so
            // o_mean is valid in the same cycle as o_done.
            mean_q  <= err_flag_q ? '0 : quo_d;
            done_q  <= 1'b1;
            err_q   <= err_flag_q;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rd_en     = rd_en_q;
  assign o_rd_addr   = addr_q;
  assign o_sum_start = sum_start_q;
  assign o_sum_valid = sum_valid_q;
  assign o_sum_data  = i_rd_data;
  assign o_sum_last  = sum_last_q;
  assign o_mean      = mean_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_pa_cal_mean_ctrl.sv
// Testbench for pa_cal_mean_ctrl: RAM and sum-unit models, directed runs,
// scoreboard queues filled at stimulus time and drained by a monitor.
module tb_pa_cal_mean_ctrl;
  localparam int SD = 32;
  localparam int SA = 10;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic [SA:0]   i_num_elem = '0;
  logic          o_rd_en;
  logic [SA-1:0] o_rd_addr;
  logic [SD-1:0] i_rd_data;
  logic          o_sum_start;
  logic          o_sum_valid;
  logic [SD-1:0] o_sum_data;
  logic          o_sum_last;
  logic [SD-1:0] i_sum;
  logic          i_sum_done;
  logic [SD-1:0] o_mean;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  pa_cal_mean_ctrl #(.SIZE_DATA(SD), .SIZE_ADDR(SA)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_elem(i_num_elem),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_sum_start(o_sum_start), .o_sum_valid(o_sum_valid), .o_sum_data(o_sum_data),
    .o_sum_last(o_sum_last), .i_sum(i_sum), .i_sum_done(i_sum_done),
    .o_mean(o_mean), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    int          cyc;
    logic [SD-1:0] v;
    logic        e;
  } exp_t;

  exp_t q_st[$];
  exp_t q_rd[$];
  exp_t q_vl[$];
  exp_t q_ls[$];
  exp_t q_dn[$];

  // RAM and sum-unit models
  logic [SD-1:0] mem [0:1023];
  logic [SD-1:0] ram_q = '0;
  logic [SD-1:0] acc = '0;
  logic          sd_q = 1'b0;
  logic          stray = 1'b0;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_rd_en) ram_q <= mem[o_rd_addr];
    if (o_sum_start) acc <= '0;
    else if (o_sum_valid) acc <= acc + o_sum_data;
    sd_q <= o_sum_last;
  end

  assign i_rd_data  = ram_q;
  assign i_sum      = acc;
  assign i_sum_done = sd_q | stray;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    total++;
    bad++;
    $display("FAIL unexpected %s: got asserted want none (cycle %0d)", nm, cyc);
  endtask

  function automatic exp_t mk(input int c, input logic [SD-1:0] v, input logic e);
    exp_t r;
    r.cyc = c;
    r.v   = v;
    r.e   = e;
    return r;
  endfunction

  // Monitor
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_rst_n) begin
      if (o_sum_start) begin
        if (q_st.size() == 0) unexp("sum_start");
        else begin e = q_st.pop_front(); chk("sum_start_cyc", 64'(cyc), 64'(e.cyc)); end
      end
      if (o_rd_en) begin
        if (q_rd.size() == 0) unexp("rd_en");
        else begin
          e = q_rd.pop_front();
          chk("rd_cyc", 64'(cyc), 64'(e.cyc));
          chk("rd_addr", 64'(o_rd_addr), 64'(e.v));
        end
      end
      if (o_sum_valid) begin
        if (q_vl.size() == 0) unexp("sum_valid");
        else begin
          e = q_vl.pop_front();
          chk("valid_cyc", 64'(cyc), 64'(e.cyc));
          chk("sum_data", 64'(o_sum_data), 64'(e.v));
        end
      end
      if (o_sum_last) begin
        if (q_ls.size() == 0) unexp("sum_last");
        else begin e = q_ls.pop_front(); chk("last_cyc", 64'(cyc), 64'(e.cyc)); end
      end
      if (o_done) begin
        done_cnt = done_cnt + 1;
        if (q_dn.size() == 0) unexp("done");
        else begin
          e = q_dn.pop_front();
          chk("done_cyc", 64'(cyc), 64'(e.cyc));
          chk("mean", 64'(o_mean), 64'(e.v));
          chk("err", 64'(o_err), 64'(e.e));
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, 64'(o_rd_en), 0);
    chk({tag, "_rd_addr"}, 64'(o_rd_addr), 0);
    chk({tag, "_sum_start"}, 64'(o_sum_start), 0);
    chk({tag, "_sum_valid"}, 64'(o_sum_valid), 0);
    chk({tag, "_sum_last"}, 64'(o_sum_last), 0);
    chk({tag, "_mean"}, 64'(o_mean), 0);
    chk({tag, "_busy"}, 64'(o_busy), 0);
    chk({tag, "_done"}, 64'(o_done), 0);
    chk({tag, "_err"}, 64'(o_err), 0);
  endtask

  // One transaction; p1/p2 are cycles in which an extra i_start is pulsed.
  task automatic run(input int n, input logic [SD-1:0] exp_mean, input int p1, input int p2);
    int   c;
    int   d0;
    bit   got;
    bit   is_err;
    @(negedge i_clk);
    c = cyc;
    is_err = (n == 0) || (n > 1024);
    if (is_err) begin
      q_dn.push_back(mk(c + 1, '0, 1'b1));
    end else begin
      q_st.push_back(mk(c + 1, '0, 1'b0));
      for (int j = 0; j < n; j++) begin
        q_rd.push_back(mk(c + 2 + j, SD'(j), 1'b0));
        q_vl.push_back(mk(c + 3 + j, mem[j], 1'b0));
      end
      q_ls.push_back(mk(c + n + 2, '0, 1'b0));
      q_dn.push_back(mk(c + n + 36, exp_mean, 1'b0));
    end
    i_num_elem = n[SA:0];
    i_start = 1'b1;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 1; i <= n + 60 && !got; i++) begin
      @(negedge i_clk);
      i_start = (i == p1) || (i == p2);
      #1;
      if (i == 1) chk("busy_cycle1", 64'(o_busy), 1);
      if (done_cnt != d0) got = 1'b1;
    end
    i_start = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout n=%0d: got no done want done", n);
    end else begin
      @(negedge i_clk);
      #1;
      chk("busy_after_done", 64'(o_busy), 0);
    end
  endtask

  initial begin
    int c;
    for (int j = 0; j < 1024; j++) mem[j] = '0;

    #1 i_rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
    run(4, 32'd25, 0, 0);

    mem[0] = 1; mem[1] = 1; mem[2] = 2;
    run(3, 32'd1, 0, 0);

    mem[0] = 7;
    run(1, 32'd7, 0, 0);

    run(0, 32'd0, 0, 0);
    run(1025, 32'd0, 0, 0);

    for (int j = 0; j < 1024; j++) mem[j] = 32'h0000FFFF;
    run(1024, 32'h0000FFFF, 0, 0);

    mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
    run(4, 32'd25, 3, 20);

    // Reset during READ of an N=8 run
    for (int j = 0; j < 8; j++) mem[j] = SD'(100 + j);
    @(negedge i_clk);
    c = cyc;
    q_st.push_back(mk(c + 1, '0, 1'b0));
    q_rd.push_back(mk(c + 2, SD'(0), 1'b0));
    q_rd.push_back(mk(c + 3, SD'(1), 1'b0));
    q_vl.push_back(mk(c + 3, mem[0], 1'b0));
    i_num_elem = 11'd8;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("midrst_pending", 64'(q_st.size() + q_rd.size() + q_vl.size() + q_dn.size()), 0);

    // Stray sum-done in IDLE must not start anything
    @(negedge i_clk);
    stray = 1'b1;
    @(negedge i_clk);
    stray = 1'b0;
    #1;
    chk("stray_busy", 64'(o_busy), 0);
    chk("stray_done", 64'(o_done), 0);

    mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
    run(4, 32'd25, 0, 0);

    repeat (3) @(negedge i_clk);
    chk("leftover", 64'(q_st.size() + q_rd.size() + q_vl.size() + q_ls.size() + q_dn.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
